// File: rtl/loopyv_dmem_responder.sv
// Data-memory responder for the loopyV MEM stage: byte/half/word loads and stores on a word-wide RAM.
// Latency: store/error response visible 1 cycle after accept, load response 2 cycles after accept.
// Backpressure: one request in flight; reqReady low until the response is taken with respReady.
// Optional build macro LOOPYV_MISALIGN_TRAP_EN: misaligned H/HU/W accesses respond with an error instead of aligning down.
module loopyv_dmem_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqLoad,
  input  logic        reqStore,
  input  logic [2:0]  reqByteSelect,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqStoreData,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] respLoadData,
  output logic        respError
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Word-wide RAM with individually writable byte lanes; never reset.
  logic [3:0][7:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          do_write;
  logic          do_read;
  logic [AW-1:0] word_idx;
  logic [1:0]    eff_off;
  logic          bad_op;
  logic          req_err;
  logic [3:0]    lane_en;
  logic [31:0]   wr_data;

  logic [31:0]   rd_word;
  logic [2:0]    ld_f3;
  logic [1:0]    ld_off;
  logic [31:0]   ext_data;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;

  logic [31:0]   resp_data;
  logic          resp_err;

  // Upper address bits only wrap the RAM; they carry no meaning here.
  logic unused_addr_hi;
  assign unused_addr_hi = ^reqAddr[31:AW+2];

  assign word_idx = reqAddr[AW+1:2];
  // A handshake coinciding with reset is discarded.
  assign accept   = reqValid && (state == IDLE) && !reset;
  assign do_write = accept && reqStore && !req_err;
  assign do_read  = accept && reqLoad && !req_err;

`ifdef LOOPYV_MISALIGN_TRAP_EN
  logic misalign;
  // Offset bits that an H/HU or W access is not allowed to carry.
  always_comb begin
    case (reqByteSelect[1:0])
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = reqAddr[0];
      default: misalign = |reqAddr[1:0];
    endcase
  end
`endif

  // Request decode: legality, effective lane offset, lane enables and replicated store data.
  always_comb begin
    bad_op = (reqLoad == reqStore)
          || (reqByteSelect == 3'b011)
          || (reqByteSelect == 3'b110)
          || (reqByteSelect == 3'b111)
          || (reqStore && reqByteSelect[2]);
`ifdef LOOPYV_MISALIGN_TRAP_EN
    req_err = bad_op || misalign;
`else
    req_err = bad_op;
`endif
    case (reqByteSelect[1:0])
      2'b00: begin
        eff_off = reqAddr[1:0];
        lane_en = 4'b0001 << eff_off;
        wr_data = {4{reqStoreData[7:0]}};
      end
      2'b01: begin
        eff_off = {reqAddr[1], 1'b0};
        lane_en = 4'b0011 << eff_off;
        wr_data = {2{reqStoreData[15:0]}};
      end
      default: begin
        eff_off = 2'b00;
        lane_en = 4'b1111;
        wr_data = reqStoreData;
      end
    endcase
  end

  // RAM port: lane writes and the synchronous read both happen on the accept edge.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[word_idx][i] <= wr_data[8*i +: 8];
      end
    end
    if (do_read) rd_word <= mem[word_idx];
  end

  // Remember how to extract and extend the load result while the RAM read completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_f3  <= 3'b010;
      ld_off <= 2'b00;
    end else if (do_read) begin
      ld_f3  <= reqByteSelect;
      ld_off <= eff_off;
    end
  end

  // Lane selection and sign/zero extension of the read word.
  always_comb begin
    sel_byte = rd_word[{ld_off, 3'b000} +: 8];
    sel_half = rd_word[{ld_off[1], 4'b0000} +: 16];
    case (ld_f3)
      3'b000:  ext_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  ext_data = {{16{sel_half[15]}}, sel_half};
      3'b100:  ext_data = {24'd0, sel_byte};
      3'b101:  ext_data = {16'd0, sel_half};
      default: ext_data = rd_word;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: loads detour through READ, stores and errors go straight to RESP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = do_read ? READ : RESP;
      end
      READ:    state_nxt = RESP;
      RESP: begin
        if (respReady) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response registers: held steady through RESP, cleared once the response is consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_data <= 32'd0;
      resp_err  <= 1'b0;
    end else if (accept) begin
      resp_data <= 32'd0;
      resp_err  <= req_err;
    end else if (state == READ) begin
      resp_data <= ext_data;
      resp_err  <= 1'b0;
    end else if ((state == RESP) && respReady) begin
      resp_data <= 32'd0;
      resp_err  <= 1'b0;
    end
  end

  // Output decode.
  always_comb begin
    reqReady     = (state == IDLE);
    respValid    = (state == RESP);
    respLoadData = resp_data;
    respError    = resp_err;
  end

endmodule

// File: tb/tb_loopyv_dmem_responder.sv
// Bench for loopyv_dmem_responder: directed scenarios plus random traffic against a byte-array model.
// Checks latency, response data/error, stall stability, ignored requests and reset behaviour.
// All waits on the DUT are bounded.
module tb_loopyv_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int BYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic        reqLoad;
  logic        reqStore;
  logic [2:0]  reqByteSelect;
  logic [31:0] reqAddr;
  logic [31:0] reqStoreData;
  logic        respValid;
  logic        respReady;
  logic [31:0] respLoadData;
  logic        respError;

  always #5 clk = ~clk;

  loopyv_dmem_responder #(.DEPTH_WORDS(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .reqValid     (reqValid),
    .reqReady     (reqReady),
    .reqLoad      (reqLoad),
    .reqStore     (reqStore),
    .reqByteSelect(reqByteSelect),
    .reqAddr      (reqAddr),
    .reqStoreData (reqStoreData),
    .respValid    (respValid),
    .respReady    (respReady),
    .respLoadData (respLoadData),
    .respError    (respError)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference memory as a flat byte array.
  logic [7:0] mem_b [BYTES];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural model of one access: legality, alignment, byte writes, extension.
  function automatic void ref_access(input logic ld, input logic st, input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] wd,
                                     output logic err, output logic [31:0] d);
    int sz;
    int base;
    logic [31:0] v;
    err = 1'b0;
    d   = 32'd0;
    case (f3[1:0])
      2'b00:   sz = 1;
      2'b01:   sz = 2;
      default: sz = 4;
    endcase
    if (ld == st || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (st && f3[2])) err = 1'b1;
    base = int'(a % 32'(BYTES));
`ifdef LOOPYV_MISALIGN_TRAP_EN
    if (base % sz != 0) err = 1'b1;
`endif
    base = base - (base % sz);
    if (err) return;
    if (st) begin
      for (int i = 0; i < sz; i++) mem_b[base + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < sz; i++) v = v | ({24'd0, mem_b[base + i]} << (8 * i));
      if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
      d = v;
    end
  endfunction

  // One complete transaction: issue, measure latency, check response, optional stall, consume.
  task automatic do_req(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input int stall,
                        input string tag, output logic [31:0] got, output logic got_err);
    logic        exp_err;
    logic [31:0] exp_dat;
    int          lat;
    int          exp_lat;
    ref_access(ld, st, f3, addr, wd, exp_err, exp_dat);
    exp_lat = (ld && !st && !exp_err) ? 2 : 1;
    @(negedge clk);
    chk({tag, "_rdy"}, {31'd0, reqReady}, 32'd1);
    reqValid      = 1'b1;
    reqLoad       = ld;
    reqStore      = st;
    reqByteSelect = f3;
    reqAddr       = addr;
    reqStoreData  = wd;
    @(posedge clk);
    #1;
    reqValid      = 1'b0;
    reqLoad       = 1'($urandom_range(0, 1));
    reqStore      = 1'($urandom_range(0, 1));
    reqByteSelect = 3'($urandom_range(0, 7));
    reqAddr       = $urandom();
    reqStoreData  = $urandom();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!respValid && lat < 8);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_dat"}, respLoadData, exp_dat);
    chk({tag, "_err"}, {31'd0, respError}, {31'd0, exp_err});
    got     = respLoadData;
    got_err = respError;
    for (int s = 0; s < stall; s++) begin
      reqValid      = 1'b1;
      reqLoad       = 1'b0;
      reqStore      = 1'b1;
      reqByteSelect = 3'b010;
      reqAddr       = 32'h0000_0100;
      reqStoreData  = $urandom();
      @(negedge clk);
      chk({tag, "_stall_vld"}, {31'd0, respValid}, 32'd1);
      chk({tag, "_stall_dat"}, respLoadData, exp_dat);
      chk({tag, "_stall_err"}, {31'd0, respError}, {31'd0, exp_err});
      chk({tag, "_stall_rdy"}, {31'd0, reqReady}, 32'd0);
    end
    reqValid  = 1'b0;
    respReady = 1'b1;
    @(posedge clk);
    #1;
    respReady = 1'b0;
    @(negedge clk);
    chk({tag, "_done_vld"}, {31'd0, respValid}, 32'd0);
    chk({tag, "_done_rdy"}, {31'd0, reqReady}, 32'd1);
  endtask

  initial begin
    logic [31:0] got;
    logic        gerr;
    logic        e;
    logic [31:0] d;
    logic [2:0]  f3s [5];
    int          r;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;

    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    reset = 1'b1; reqValid = 1'b0; reqLoad = 1'b0; reqStore = 1'b0;
    reqByteSelect = 3'b000; reqAddr = 32'd0; reqStoreData = 32'd0; respReady = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", {31'd0, reqReady}, 32'd1);
    chk("rst_vld", {31'd0, respValid}, 32'd0);
    chk("rst_err", {31'd0, respError}, 32'd0);
    chk("rst_dat", respLoadData, 32'd0);
    reset = 1'b0;

    // Give the exercised region (words 0..127) defined contents.
    for (int w = 0; w < 128; w++) do_req(1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom(), 0, "init", got, gerr);

    // Word store then load.
    do_req(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, "sw100", got, gerr);
    do_req(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 0, "lw100", got, gerr);
    chk("lw100_const", got, 32'hDEADBEEF);

    // Byte store and signed/unsigned byte loads.
    do_req(1'b0, 1'b1, 3'b000, 32'h101, 32'h0000_0080, 0, "sb101", got, gerr);
    do_req(1'b1, 1'b0, 3'b000, 32'h101, 32'd0, 0, "lb101", got, gerr);
    chk("lb101_const", got, 32'hFFFFFF80);
    do_req(1'b1, 1'b0, 3'b100, 32'h101, 32'd0, 0, "lbu101", got, gerr);
    chk("lbu101_const", got, 32'h00000080);
    do_req(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 0, "lw100b", got, gerr);
    chk("lw100b_const", got, 32'hDEAD80EF);

    // Halfword store, signed/unsigned halfword loads, and address aliasing.
    do_req(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_8001, 0, "sh102", got, gerr);
    do_req(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 0, "lh102", got, gerr);
    chk("lh102_const", got, 32'hFFFF8001);
    do_req(1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 0, "lhu102", got, gerr);
    chk("lhu102_const", got, 32'h00008001);
    do_req(1'b1, 1'b0, 3'b010, 32'h100 + 32'(DEPTH * 4), 32'd0, 0, "lw_alias", got, gerr);
    chk("lw_alias_const", got, 32'h800180EF);

    // Long response stall with stray requests that must be ignored.
    do_req(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 5, "stall5", got, gerr);
    do_req(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 0, "post_stall", got, gerr);
    chk("post_stall_const", got, 32'h800180EF);

    // Illegal operations.
    do_req(1'b1, 1'b0, 3'b011, 32'h100, 32'd0, 0, "f3_011", got, gerr);
    chk("f3_011_errc", {31'd0, gerr}, 32'd1);
    do_req(1'b1, 1'b1, 3'b010, 32'h100, 32'hFFFFFFFF, 0, "ld_st", got, gerr);
    chk("ld_st_errc", {31'd0, gerr}, 32'd1);
    do_req(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 0, "post_err", got, gerr);
    chk("post_err_const", got, 32'h800180EF);

    // Misaligned word load.
    do_req(1'b1, 1'b0, 3'b010, 32'h102, 32'd0, 0, "lw102", got, gerr);
`ifdef LOOPYV_MISALIGN_TRAP_EN
    chk("lw102_errc", {31'd0, gerr}, 32'd1);
`else
    chk("lw102_const", got, 32'h800180EF);
`endif

    // Reset while a load is in READ.
    @(negedge clk);
    reqValid = 1'b1; reqLoad = 1'b1; reqStore = 1'b0; reqByteSelect = 3'b010; reqAddr = 32'h100;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    @(negedge clk);
    chk("rst_read_pre", {31'd0, respValid}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_read_rdy", {31'd0, reqReady}, 32'd1);
    chk("rst_read_vld", {31'd0, respValid}, 32'd0);
    chk("rst_read_dat", respLoadData, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_read_quiet", {31'd0, respValid}, 32'd0);
    end
    do_req(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 0, "rst_read_mem", got, gerr);
    chk("rst_read_mem_const", got, 32'h800180EF);

    // Reset on the same edge as a store handshake: store must not happen.
    @(negedge clk);
    reqValid = 1'b1; reqLoad = 1'b0; reqStore = 1'b1; reqByteSelect = 3'b010;
    reqAddr = 32'h104; reqStoreData = 32'h12345678; reset = 1'b1;
    @(posedge clk);
    #1;
    reqValid = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("rst_same_vld", {31'd0, respValid}, 32'd0);
    chk("rst_same_rdy", {31'd0, reqReady}, 32'd1);
    do_req(1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 0, "rst_same_mem", got, gerr);

    // Reset while a store response waits in RESP: the write stays.
    ref_access(1'b0, 1'b1, 3'b010, 32'h108, 32'hCAFEF00D, e, d);
    @(negedge clk);
    reqValid = 1'b1; reqLoad = 1'b0; reqStore = 1'b1; reqByteSelect = 3'b010;
    reqAddr = 32'h108; reqStoreData = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    @(negedge clk);
    chk("rst_resp_pre", {31'd0, respValid}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_resp_vld", {31'd0, respValid}, 32'd0);
    chk("rst_resp_err", {31'd0, respError}, 32'd0);
    do_req(1'b1, 1'b0, 3'b010, 32'h108, 32'd0, 0, "rst_resp_mem", got, gerr);
    chk("rst_resp_mem_const", got, 32'hCAFEF00D);

    // Random traffic over words 0..127 with random high address bits.
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 19);
      if (r < 8) begin
        ld = 1'b1; st = 1'b0; f3 = f3s[$urandom_range(0, 4)];
      end else if (r < 16) begin
        ld = 1'b0; st = 1'b1; f3 = f3s[$urandom_range(0, 2)];
      end else begin
        ld = 1'($urandom_range(0, 1)); st = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
      end
      addr = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 511));
      do_req(ld, st, f3, addr, $urandom(), $urandom_range(0, 2), "rand", got, gerr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
